// File: rtl/fp_sub_seq.sv
// fp_sub_seq: multi-cycle IEEE-754 subtractor (out = A - B, RNE), bit-serial normalizer.
// Define FP_SUB_FLAGS_EN to add the registered fflags {NV,DZ,OF,UF,NX} output.
`timescale 1ns/1ps
module fp_sub_seq #(
    parameter int BUS_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BUS_WIDTH-1:0] A,
    input  logic [BUS_WIDTH-1:0] B,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BUS_WIDTH-1:0] out
`ifdef FP_SUB_FLAGS_EN
    ,
    output logic [4:0]           fflags
`endif
);
    localparam int EW  = (BUS_WIDTH == 32) ? 8 : 11;
    localparam int FW  = BUS_WIDTH - EW - 1;
    localparam int MW  = FW + 1;
    localparam int XW  = MW + 4;
    localparam int IEW = EW + 2;

    localparam logic [IEW-1:0] EXP_ONE   = IEW'(1);
    localparam logic [IEW-1:0] EXP_INF   = IEW'((1 << EW) - 1);
    localparam logic [IEW-1:0] SHIFT_MAX = IEW'(MW + 3);
    localparam logic [BUS_WIDTH-1:0] QNAN =
        {1'b0, {EW{1'b1}}, 1'b1, {(FW-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE, UNPACK, ALIGN, ADDSUB, NORM, ROUND, DONE
    } state_t;

    state_t               state;
    logic [BUS_WIDTH-1:0] a_r, b_r;
    logic                 sx, sy, sz, eff_sub;
    logic [IEW-1:0]       ex, ey, ez;
    logic [MW-1:0]        mx, my;
    logic [XW-1:0]        y_r, acc;

    logic                 sa, sb;
    logic [EW-1:0]        ea_f, eb_f;
    logic [FW-1:0]        fa, fb;
    logic [MW-1:0]        ma, mb;
    logic [IEW-1:0]       ea, eb;
    logic                 a_big, a_nan, b_nan, a_inf, b_inf;
    logic                 special, inf_clash;
    logic [BUS_WIDTH-1:0] special_res;

    // B enters with its sign flipped so the rest of the path is an adder.
    assign sa   = a_r[BUS_WIDTH-1];
    assign sb   = ~b_r[BUS_WIDTH-1];
    assign ea_f = a_r[BUS_WIDTH-2 -: EW];
    assign eb_f = b_r[BUS_WIDTH-2 -: EW];
    assign fa   = a_r[FW-1:0];
    assign fb   = b_r[FW-1:0];
    assign ma   = {|ea_f, fa};
    assign mb   = {|eb_f, fb};
    assign ea   = (|ea_f) ? IEW'(ea_f) : EXP_ONE;
    assign eb   = (|eb_f) ? IEW'(eb_f) : EXP_ONE;

    assign a_big = (ea > eb) || ((ea == eb) && (ma >= mb));
    assign a_nan = (&ea_f) && (|fa);
    assign b_nan = (&eb_f) && (|fb);
    assign a_inf = (&ea_f) && !(|fa);
    assign b_inf = (&eb_f) && !(|fb);

    assign special   = (&ea_f) || (&eb_f);
    assign inf_clash = a_inf && b_inf && (sa != sb);

    always_comb begin
        special_res = QNAN;
        if (a_nan || b_nan || inf_clash)
            special_res = QNAN;
        else if (a_inf)
            special_res = {sa, {EW{1'b1}}, {FW{1'b0}}};
        else if (b_inf)
            special_res = {sb, {EW{1'b1}}, {FW{1'b0}}};
    end

    logic [IEW-1:0] d;
    logic [MW+1:0]  y_val, y_sh, y_mask;
    logic [XW-1:0]  y_ext, x_ext;

    assign d      = ex - ey;
    assign y_val  = {my, 2'b00};
    assign y_sh   = y_val >> d;
    assign y_mask = ~({(MW+2){1'b1}} << d);
    assign y_ext  = (d >= SHIFT_MAX) ?
                    {{(XW-1){1'b0}}, |my} :
                    {1'b0, y_sh, |(y_val & y_mask)};
    assign x_ext  = {1'b0, mx, 3'b000};

    logic [MW-1:0]        rnd_mant, rm_n;
    logic                 g_b, r_b, s_b, inc;
    logic [MW:0]          rm;
    logic [IEW-1:0]       re;
    logic                 ovf, z_sign;
    logic [BUS_WIDTH-1:0] rnd_res;

    assign rnd_mant      = acc[XW-2:3];
    assign {g_b, r_b, s_b} = acc[2:0];
    assign inc           = g_b & (r_b | s_b | rnd_mant[0]);
    assign rm            = {1'b0, rnd_mant} + {{MW{1'b0}}, inc};
    assign rm_n          = rm[MW] ? rm[MW:1] : rm[MW-1:0];
    assign re            = rm[MW] ? ez + EXP_ONE : ez;
    assign ovf           = rm_n[MW-1] && (re >= EXP_INF);
    // Exact cancellation yields +0; only -0 + -0 keeps the negative sign.
    assign z_sign        = (acc == '0) ? (sz & ~eff_sub) : sz;

    always_comb begin
        rnd_res = {z_sign,
                   rm_n[MW-1] ? re[EW-1:0] : {EW{1'b0}},
                   rm_n[FW-1:0]};
        if (ovf)
            rnd_res = {z_sign, {EW{1'b1}}, {FW{1'b0}}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out       <= '0;
            a_r       <= '0;
            b_r       <= '0;
            sx        <= 1'b0;
            sy        <= 1'b0;
            sz        <= 1'b0;
            eff_sub   <= 1'b0;
            ex        <= '0;
            ey        <= '0;
            ez        <= '0;
            mx        <= '0;
            my        <= '0;
            y_r       <= '0;
            acc       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r      <= A;
                        b_r      <= B;
                        in_ready <= 1'b0;
                        state    <= UNPACK;
                    end
                end
                UNPACK: begin
                    if (special) begin
                        out   <= special_res;
                        state <= DONE;
                    end else begin
                        if (a_big) begin
                            sx <= sa; ex <= ea; mx <= ma;
                            sy <= sb; ey <= eb; my <= mb;
                        end else begin
                            sx <= sb; ex <= eb; mx <= mb;
                            sy <= sa; ey <= ea; my <= ma;
                        end
                        state <= ALIGN;
                    end
                end
                ALIGN: begin
                    y_r   <= y_ext;
                    state <= ADDSUB;
                end
                ADDSUB: begin
                    acc     <= (sx ^ sy) ? x_ext - y_r : x_ext + y_r;
                    eff_sub <= sx ^ sy;
                    ez      <= ex;
                    sz      <= sx;
                    state   <= NORM;
                end
                NORM: begin
                    if (acc[XW-1]) begin
                        acc <= {1'b0, acc[XW-1:2], acc[1] | acc[0]};
                        ez  <= ez + EXP_ONE;
                    end else if (!acc[XW-2] && (ez > EXP_ONE)) begin
                        acc <= {acc[XW-2:0], acc[0]};
                        ez  <= ez - EXP_ONE;
                    end else begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    out       <= rnd_res;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FP_SUB_FLAGS_EN
    logic a_snan, b_snan, sp_nv, rnd_nx;

    assign a_snan = a_nan && !fa[FW-1];
    assign b_snan = b_nan && !fb[FW-1];
    assign sp_nv  = a_snan || b_snan || inf_clash;
    assign rnd_nx = g_b | r_b | s_b | ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fflags <= '0;
        else if ((state == UNPACK) && special)
            fflags <= {sp_nv, 4'b0000};
        else if (state == ROUND)
            fflags <= {2'b00, ovf, ~rm_n[MW-1] & rnd_nx, rnd_nx};
    end
`endif

endmodule

// File: tb/tb_fp_sub_seq.sv
// tb_fp_sub_seq: scoreboard bench for fp_sub_seq, binary64 random + binary32 directed.
// Reference is the simulator's native double subtraction plus NaN canonicalisation.
`timescale 1ns/1ps
module tb_fp_sub_seq;
    localparam logic [63:0] QNAN64 = 64'h7FF8_0000_0000_0000;
    localparam int TMO = 3000;

    typedef struct {
        logic [63:0] res;
        int          lat;
        logic [4:0]  fl;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        out_ready;
    logic        in_valid, in_ready, out_valid;
    logic [63:0] a, b, res;
    logic        in_valid32, in_ready32, out_valid32;
    logic [31:0] a32, b32, res32;
`ifdef FP_SUB_FLAGS_EN
    logic [4:0]  flags, flags32;
`endif

    exp_t q[$];
    exp_t q32[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cyc, rise_cyc, acc_cyc32, rise_cyc32;
    logic prev_v, prev_v32;
    int   rdy_mode = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fp_sub_seq #(.BUS_WIDTH(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(a), .B(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(res)
`ifdef FP_SUB_FLAGS_EN
        , .fflags(flags)
`endif
    );

    fp_sub_seq #(.BUS_WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid32), .in_ready(in_ready32),
        .A(a32), .B(b32),
        .out_valid(out_valid32), .out_ready(out_ready),
        .out(res32)
`ifdef FP_SUB_FLAGS_EN
        , .fflags(flags32)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, want, $time);
        end
    endtask

    function automatic logic is_nan(input logic [63:0] x);
        return (x[62:52] == 11'h7FF) && (x[51:0] != 0);
    endfunction

    function automatic logic is_inf(input logic [63:0] x);
        return (x[62:52] == 11'h7FF) && (x[51:0] == 0);
    endfunction

    function automatic logic is_snan(input logic [63:0] x);
        return is_nan(x) && !x[51];
    endfunction

    function automatic logic [63:0] ref_sub(input logic [63:0] x, y);
        if (is_nan(x) || is_nan(y)) return QNAN64;
        if (is_inf(x) && is_inf(y) && (x[63] == y[63])) return QNAN64;
        return $realtobits($bitstoreal(x) - $bitstoreal(y));
    endfunction

    // Only NV and OF are predicted; DZ must stay 0.
    function automatic logic [4:0] ref_flags(input logic [63:0] x, y, r);
        logic nv, of;
        nv = is_snan(x) || is_snan(y) ||
             (is_inf(x) && is_inf(y) && (x[63] == y[63]));
        of = is_inf(r) && !is_inf(x) && !is_inf(y) &&
             !is_nan(x) && !is_nan(y);
        return {nv, 1'b0, of, 2'b00};
    endfunction

    function automatic logic [63:0] spec_val(input int i);
        case (i)
            0: return 64'h7FF0_0000_0000_0000;
            1: return 64'hFFF0_0000_0000_0000;
            2: return 64'h7FF8_0000_0000_0001;
            3: return 64'h7FF0_0000_0000_0001;
            4: return 64'h0000_0000_0000_0000;
            5: return 64'h8000_0000_0000_0000;
            6: return 64'h7FEF_FFFF_FFFF_FFFF;
            default: return 64'h0010_0000_0000_0000;
        endcase
    endfunction

    function automatic logic [63:0] rand_a();
        logic [63:0] v;
        v = {$urandom, $urandom};
        case ($urandom_range(0, 5))
            0: v[62:52] = 11'd1019 + 11'($urandom_range(0, 8));
            1: v[62:52] = 11'($urandom_range(0, 3));
            2: v[62:52] = 11'd2045 + 11'($urandom_range(0, 1));
            3: v = spec_val($urandom_range(0, 7));
            default: ;
        endcase
        return v;
    endfunction

    function automatic logic [63:0] rand_b(input logic [63:0] x);
        logic [63:0] v;
        int m;
        v = {$urandom, $urandom};
        m = $urandom_range(0, 19);
        if (m < 4) begin
        end else if (m < 10) begin
            v[62:52] = x[62:52] + 11'($urandom_range(0, 4)) - 11'd2;
        end else if (m < 13) begin
            v = x;
            v[7:0] = 8'($urandom);
        end else if (m == 13) begin
            v = x;
        end else if (m < 16) begin
            v[62:52] = '0;
        end else if (m == 16) begin
            v = spec_val($urandom_range(0, 7));
        end else if (m == 17) begin
            v = x;
            v[63] = ~x[63];
        end else begin
            v[62:52] = 11'($urandom_range(1, 3));
        end
        return v;
    endfunction

    task automatic issue(input logic [63:0] x, y, want, input int lat);
        int   n;
        exp_t e;
        n = 0;
        while (!in_ready && n < TMO) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL issue64: in_ready low after %0d cycles", TMO);
            return;
        end
        e.res = want;
        e.lat = ((x[62:52] == 11'h7FF) || (y[62:52] == 11'h7FF)) ? 2 : lat;
        e.fl  = ref_flags(x, y, want);
        q.push_back(e);
        a = x;
        b = y;
        in_valid = 1'b1;
        @(posedge clk); #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    task automatic issue32(input logic [31:0] x, y, want, input int lat);
        int   n;
        exp_t e;
        n = 0;
        while (!in_ready32 && n < TMO) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!in_ready32) begin
            errors++;
            $display("FAIL issue32: in_ready low after %0d cycles", TMO);
            return;
        end
        e.res = {32'h0, want};
        e.lat = lat;
        e.fl  = '0;
        q32.push_back(e);
        a32 = x;
        b32 = y;
        in_valid32 = 1'b1;
        @(posedge clk); #1;
        acc_cyc32  = cyc;
        in_valid32 = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || q32.size() != 0 || !in_ready || !in_ready32)
               && n < TMO) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_pending", 64'(q.size() + q32.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (out_valid && !prev_v) rise_cyc = cyc;
            prev_v = out_valid;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_out64", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("result64", res, e.res);
                    if (e.lat >= 0)
                        chk("latency64", 64'(rise_cyc - acc_cyc), 64'(e.lat));
`ifdef FP_SUB_FLAGS_EN
                    chk("fflags64", {59'd0, flags & 5'b11100}, {59'd0, e.fl});
`endif
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_v32 = 1'b0;
        end else begin
            if (out_valid32 && !prev_v32) rise_cyc32 = cyc;
            prev_v32 = out_valid32;
            if (out_valid32 && out_ready) begin
                if (q32.size() == 0) begin
                    chk("unexpected_out32", 64'd1, 64'd0);
                end else begin
                    e = q32.pop_front();
                    chk("result32", {32'h0, res32}, e.res);
                    if (e.lat >= 0)
                        chk("latency32", 64'(rise_cyc32 - acc_cyc32), 64'(e.lat));
                end
            end
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (rdy_mode == 0)
                out_ready = 1'b1;
            else if (rdy_mode == 1)
                out_ready = ($urandom_range(0, 3) != 0);
            else
                out_ready = 1'b0;
        end
    end

    initial begin
        int n;
        logic [63:0] x, y;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_valid32 = 1'b0;
        a = '0; b = '0; a32 = '0; b32 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out", res, 64'd0);
        chk("rst_out32", {32'd0, res32}, 64'd0);
`ifdef FP_SUB_FLAGS_EN
        chk("rst_fflags", {59'd0, flags}, 64'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(64'h4008000000000000, 64'h3FF0000000000000, 64'h4000000000000000, 5);
        issue(64'h3FF0000000000000, 64'h3FE8000000000000, 64'h3FD0000000000000, 7);
        issue(64'h3FF0000000000000, 64'h3FF0000000000000, 64'h0000000000000000, -1);
        issue(64'h8000000000000000, 64'h0000000000000000, 64'h8000000000000000, -1);
        issue(64'h0000000000000000, 64'h0000000000000000, 64'h0000000000000000, -1);
        issue(64'h8000000000000000, 64'h8000000000000000, 64'h0000000000000000, -1);
        issue(64'h7FF0000000000000, 64'h7FF0000000000000, 64'h7FF8000000000000, 2);
        issue(64'h3FF0000000000000, 64'hBFF0000000000000, 64'h4000000000000000, 6);
        issue(64'h7FF0000000000000, 64'hFFF0000000000000, 64'h7FF0000000000000, 2);
        issue(64'h7FF0000000000001, 64'h3FF0000000000000, 64'h7FF8000000000000, 2);
        issue(64'h7FEFFFFFFFFFFFFF, 64'hFFEFFFFFFFFFFFFF, 64'h7FF0000000000000, -1);
        issue(64'h0000000000000003, 64'h0000000000000001, 64'h0000000000000002, -1);
        issue(64'h0010000000000000, 64'h0000000000000001, 64'h000FFFFFFFFFFFFF, -1);
        drain();

        rdy_mode = 2;
        issue(64'h4008000000000000, 64'h3FF0000000000000, 64'h4000000000000000, 5);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_out", res, 64'h4000000000000000);
            chk("hold_valid", {63'd0, out_valid}, 64'd1);
            chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
        end
        rdy_mode = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(out_valid && out_ready) && n < 10);
        @(posedge clk); #1;
        chk("retire_in_ready", {63'd0, in_ready}, 64'd1);
        chk("retire_out_valid", {63'd0, out_valid}, 64'd0);

        issue(64'h3FF0000000000000, 64'h3FE8000000000000, 64'h3FD0000000000000, 7);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
        chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(64'h4008000000000000, 64'h3FF0000000000000, 64'h4000000000000000, 5);
        drain();

        rdy_mode = 1;
        for (int i = 0; i < 250; i++) begin
            x = rand_a();
            y = rand_b(x);
            issue(x, y, ref_sub(x, y), -1);
        end
        drain();

        rdy_mode = 0;
        issue32(32'h40400000, 32'h3F800000, 32'h40000000, 5);
        issue32(32'h3F800000, 32'h3F400000, 32'h3E800000, 7);
        issue32(32'h7F800000, 32'h7F800000, 32'h7FC00000, 2);
        issue32(32'h3F800000, 32'h3F800000, 32'h00000000, -1);
        issue32(32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, -1);
        issue32(32'h00000003, 32'h00000001, 32'h00000002, -1);
        issue32(32'h00800000, 32'h00000001, 32'h007FFFFF, -1);
        issue32(32'h3F800001, 32'hB3800000, 32'h3F800002, -1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
